uart_rx_mailbox: RTL and testbench



---
 rtl/uart_rx_mailbox.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_mailbox.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mailbox.sv
// uart_rx_mailbox
//   8N1 UART receiver with a single-entry mailbox. The serial line is
//   synchronized, each frame is deserialized LSB first, and a correctly
//   framed byte is latched into Data_rx with a ready flag. Sticky flags
//   report a low stop bit and a byte that replaced an unread byte.
//
// Ports
//   clk          system clock (single domain)
//   reset        synchronous, active-high
//   Rx           asynchronous serial line, idle high
//   Rx_ack       one-cycle pulse; releases the mailbox and clears flags
//   Data_rx      last correctly framed byte
//   Rx_ready     mailbox holds an unread byte
//   Frame_error  sticky; a stop bit was sampled low
//   Overrun      sticky; a new byte replaced an unread byte
//   Busy         receiver is in any state other than IDLE
//
// State table
//   state   | meaning
//   IDLE    | line idle, waiting for a falling edge on rx_s
//   START   | timing to the middle of the start bit, glitch check
//   DATA    | sampling data bits one bit period apart
//   STOP    | sampling the stop bit, mailbox update
//   BREAK   | stop bit was low; wait for the line to return high
//
// CLKS_PER_BIT must be at least 4 for the half-bit start check to work.

module uart_rx_mailbox #(
  parameter int REFERENCE_CLOCK = 50_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int WORD_LENGTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Rx,
  input  logic                   Rx_ack,
  output logic [WORD_LENGTH-1:0] Data_rx,
  output logic                   Rx_ready,
  output logic                   Frame_error,
  output logic                   Overrun,
  output logic                   Busy
);

  localparam int CLKS_PER_BIT = REFERENCE_CLOCK / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(WORD_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          idx_q, idx_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;
  logic                   busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q;
    fe_d    = fe_q;
    ov_d    = ov_q;

    // Ack clears the mailbox; a completing frame below overrides this.
    if (Rx_ack) begin
      ready_d = 1'b0;
      fe_d    = 1'b0;
      ov_d    = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[WORD_LENGTH-1:1]};
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            // Unread byte replaced unless it is acked on this same edge.
            if (ready_q) ov_d = ov_q | ~Rx_ack;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign Data_rx     = data_q;
  assign Rx_ready    = ready_q;
  assign Frame_error = fe_q;
  assign Overrun     = ov_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_mailbox.sv
// tb_uart_rx_mailbox
//   Self-checking bench for uart_rx_mailbox with CLKS_PER_BIT = 16.
//   Expected bytes go into a scoreboard queue when a good frame is driven
//   and are popped when the frame's completion edge has passed.
//   Edge numbering: edge 1 is the first clk edge that samples Rx low; the
//   stop-bit sample (and Rx_ready rise) is 2+8+144 edges later, edge 155.

module tb_uart_rx_mailbox;

  logic       clk = 1'b0;
  logic       reset;
  logic       Rx;
  logic       Rx_ack;
  logic [7:0] Data_rx;
  logic       Rx_ready;
  logic       Frame_error;
  logic       Overrun;
  logic       Busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_data;

  always #5 clk = ~clk;

  uart_rx_mailbox #(
    .REFERENCE_CLOCK(16),
    .BAUD_RATE      (1),
    .WORD_LENGTH    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Rx         (Rx),
    .Rx_ack     (Rx_ack),
    .Data_rx    (Data_rx),
    .Rx_ready   (Rx_ready),
    .Frame_error(Frame_error),
    .Overrun    (Overrun),
    .Busy       (Busy)
  );

  // Drives one frame, one bit per 16 cycles, for n_cycles edges. Reports the
  // edge where Rx_ready rose and how often Busy disagreed with a good frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int n_cycles, input int ack_edge,
                            output int rdy_edge, output int busy_bad);
    logic [9:0] bits;
    logic       prev_rdy;
    int         bn;
    bits     = {stop_bit, b, 1'b0};
    rdy_edge = -1;
    busy_bad = 0;
    @(posedge clk); #1;
    prev_rdy = Rx_ready;
    Rx = 1'b0;
    for (int k = 1; k <= n_cycles; k++) begin
      @(posedge clk); #1;
      if (k == ack_edge - 1) Rx_ack = 1'b1;
      if (k == ack_edge)     Rx_ack = 1'b0;
      if (rdy_edge < 0 && Rx_ready === 1'b1 && prev_rdy === 1'b0) rdy_edge = k;
      prev_rdy = Rx_ready;
      if (k >= 3   && k <= 154 && Busy !== 1'b1) busy_bad++;
      if (k >= 155 && k <= 160 && Busy !== 1'b0) busy_bad++;
      bn = k / 16;
      Rx = (bn <= 9) ? bits[bn] : 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_ack();
    Rx_ack = 1'b1;
    @(posedge clk); #1;
    Rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Rx = 1'b1; Rx_ack = 1'b0;
    idle_cycles(3);
    n_cmp++; if (Data_rx !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", Data_rx); end
    n_cmp++; if (Rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", Rx_ready); end
    n_cmp++; if (Frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_fe got=%b exp=0", Frame_error); end
    n_cmp++; if (Overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ov got=%b exp=0", Overrun); end
    n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    reset = 1'b0;
    idle_cycles(3);
    model_data = 8'h00;
  endtask

  task automatic test_good_frame();
    int re, bb;
    logic [7:0] e;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 160, 0, re, bb);
    n_cmp++; if (re !== 155) begin n_fail++; $display("FAIL good_latency got=%0d exp=155", re); end
    n_cmp++; if (bb !== 0) begin n_fail++; $display("FAIL good_busy bad_cycles=%0d exp=0", bb); end
    e = exp_q.pop_front(); model_data = e;
    n_cmp++; if (Data_rx !== e) begin n_fail++; $display("FAIL good_data got=%h exp=%h", Data_rx, e); end
    n_cmp++; if (Rx_ready !== 1'b1) begin n_fail++; $display("FAIL good_ready got=%b exp=1", Rx_ready); end
    n_cmp++; if ({Frame_error, Overrun} !== 2'b00) begin n_fail++; $display("FAIL good_flags got=%b exp=00", {Frame_error, Overrun}); end
  endtask

  task automatic test_ack();
    pulse_ack();
    n_cmp++; if (Rx_ready !== 1'b0) begin n_fail++; $display("FAIL ack_ready got=%b exp=0", Rx_ready); end
    n_cmp++; if (Data_rx !== model_data) begin n_fail++; $display("FAIL ack_data got=%h exp=%h", Data_rx, model_data); end
  endtask

  task automatic test_glitch();
    logic seen_busy;
    seen_busy = 1'b0;
    Rx = 1'b0;
    idle_cycles(4);
    Rx = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (Busy === 1'b1) seen_busy = 1'b1;
    end
    n_cmp++; if (seen_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start got=%b exp=1", seen_busy); end
    n_cmp++; if ({Rx_ready, Frame_error, Busy} !== 3'b000) begin n_fail++; $display("FAIL glitch_idle rdy_fe_busy=%b exp=000", {Rx_ready, Frame_error, Busy}); end
    n_cmp++; if (Data_rx !== model_data) begin n_fail++; $display("FAIL glitch_data got=%h exp=%h", Data_rx, model_data); end
  endtask

  task automatic test_framing();
    int re, bb, hold_bad;
    logic [7:0] e;
    send_frame(8'h3C, 1'b0, 160, 0, re, bb);
    Rx = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (Busy !== 1'b1 || Rx_ready !== 1'b0) hold_bad++;
    end
    n_cmp++; if (hold_bad !== 0) begin n_fail++; $display("FAIL frame_break bad_cycles=%0d exp=0", hold_bad); end
    Rx = 1'b1;
    idle_cycles(10);
    n_cmp++; if (Frame_error !== 1'b1) begin n_fail++; $display("FAIL frame_fe got=%b exp=1", Frame_error); end
    n_cmp++; if (Data_rx !== model_data) begin n_fail++; $display("FAIL frame_data got=%h exp=%h", Data_rx, model_data); end
    n_cmp++; if ({Rx_ready, Busy} !== 2'b00) begin n_fail++; $display("FAIL frame_idle rdy_busy=%b exp=00", {Rx_ready, Busy}); end
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 160, 0, re, bb);
    e = exp_q.pop_front(); model_data = e;
    n_cmp++; if (Data_rx !== e) begin n_fail++; $display("FAIL frame_next_data got=%h exp=%h", Data_rx, e); end
    n_cmp++; if (re !== 155) begin n_fail++; $display("FAIL frame_next_latency got=%0d exp=155", re); end
    n_cmp++; if (Frame_error !== 1'b1) begin n_fail++; $display("FAIL frame_sticky got=%b exp=1", Frame_error); end
    pulse_ack();
    n_cmp++; if ({Rx_ready, Frame_error} !== 2'b00) begin n_fail++; $display("FAIL frame_ack rdy_fe=%b exp=00", {Rx_ready, Frame_error}); end
  endtask

  task automatic test_overrun();
    int re, bb;
    logic [7:0] e;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 160, 0, re, bb);
    e = exp_q.pop_front(); model_data = e;
    n_cmp++; if ({Data_rx, Rx_ready, Overrun} !== {e, 2'b10}) begin n_fail++; $display("FAIL ovr_first data_rdy_ov=%h/%b%b exp=%h/10", Data_rx, Rx_ready, Overrun, e); end
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 160, 0, re, bb);
    e = exp_q.pop_front(); model_data = e;
    n_cmp++; if (Data_rx !== e) begin n_fail++; $display("FAIL ovr_data got=%h exp=%h", Data_rx, e); end
    n_cmp++; if ({Rx_ready, Overrun} !== 2'b11) begin n_fail++; $display("FAIL ovr_flags rdy_ov=%b exp=11", {Rx_ready, Overrun}); end
    pulse_ack();
    exp_q.push_back(8'h44);
    send_frame(8'h44, 1'b1, 160, 0, re, bb);
    e = exp_q.pop_front(); model_data = e;
    n_cmp++; if ({Data_rx, Rx_ready, Overrun} !== {e, 2'b10}) begin n_fail++; $display("FAIL ovr_refill data_rdy_ov=%h/%b%b exp=%h/10", Data_rx, Rx_ready, Overrun, e); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 160, 155, re, bb);
    e = exp_q.pop_front(); model_data = e;
    n_cmp++; if (Data_rx !== e) begin n_fail++; $display("FAIL ovr_ack_data got=%h exp=%h", Data_rx, e); end
    n_cmp++; if ({Rx_ready, Overrun} !== 2'b10) begin n_fail++; $display("FAIL ovr_ack_flags rdy_ov=%b exp=10", {Rx_ready, Overrun}); end
  endtask

  task automatic test_reset_midframe();
    int re, bb;
    logic [7:0] e;
    // Mailbox holds 0x5A unread, so the reset has something to clear.
    send_frame(8'hFF, 1'b1, 80, 0, re, bb);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if ({Data_rx, Rx_ready, Frame_error, Overrun, Busy} !== 12'h000) begin n_fail++; $display("FAIL midreset_outputs data=%h rdy=%b fe=%b ov=%b busy=%b exp=all0", Data_rx, Rx_ready, Frame_error, Overrun, Busy); end
    model_data = 8'h00;
    idle_cycles(4);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 160, 0, re, bb);
    e = exp_q.pop_front(); model_data = e;
    n_cmp++; if (Data_rx !== e) begin n_fail++; $display("FAIL midreset_next_data got=%h exp=%h", Data_rx, e); end
    n_cmp++; if (re !== 155) begin n_fail++; $display("FAIL midreset_next_latency got=%0d exp=155", re); end
    n_cmp++; if ({Frame_error, Overrun} !== 2'b00) begin n_fail++; $display("FAIL midreset_flags got=%b exp=00", {Frame_error, Overrun}); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_ack();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
